serial_deserializer: RTL

- Receive side of the shift-register serial link: reassembles framed serial bit streams into DW-bit parallel words.
- Bit order is selectable per word (LSB-first or MSB-first), so it pairs with the team's PISO_LSB / PISO_MSB transmit modes.
- Delivers each word through a one-entry valid/ready holding register.
- Flags overrun and framing errors with sticky status bits.

---
 rtl/serial_deserializer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/serial_deserializer.sv
// serial_deserializer: framed serial-to-parallel receiver with a one-entry valid/ready holding register.
// Define PARITY_CHECK_EN to require an even-parity bit after each word.
module serial_deserializer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          frame,
  input  logic          serial_in,
  input  logic          msb_first,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          overrun,
  output logic          frame_err,
  output logic          parity_err,
  input  logic          clr_err
);

  localparam int CW = $clog2(DW + 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_e;
`endif

  state_e        state_q, state_d;
  logic [DW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          msb_q, msb_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  logic          word_done_s;
  logic [DW-1:0] word_s;
  logic          frame_set_s;
  logic          overrun_set_s;

  // Shifts one bit into the assembly register in the requested bit order.
  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] sr, input logic b, input logic msb);
    logic [DW-1:0] r;
    if (msb) begin
      r = {sr[DW-2:0], b};
    end else begin
      r = {b, sr[DW-1:1]};
    end
    return r;
  endfunction

`ifdef PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;
  logic parity_set_s;

  // Even parity: data bits plus parity bit carry an even number of ones.
  function automatic logic even_parity_ok(input logic [DW-1:0] w, input logic p);
    return ~((^w) ^ p);
  endfunction
`endif

  // Receive FSM: bit collection, framing and completion detection.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    msb_d       = msb_q;
    word_done_s = 1'b0;
    word_s      = sr_q;
    frame_set_s = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_set_s = 1'b0;
`endif
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (frame) begin
            msb_d   = msb_first;
            sr_d    = shift_in({DW{1'b0}}, serial_in, msb_first);
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (!frame) begin
            frame_set_s = 1'b1;
            sr_d        = {DW{1'b0}};
            cnt_d       = {CW{1'b0}};
            state_d     = IDLE;
          end else if (cnt_q == CW'(DW - 1)) begin
`ifdef PARITY_CHECK_EN
            sr_d    = shift_in(sr_q, serial_in, msb_q);
            cnt_d   = CW'(DW);
            state_d = PARITY;
`else
            word_done_s = 1'b1;
            word_s      = shift_in(sr_q, serial_in, msb_q);
            sr_d        = {DW{1'b0}};
            cnt_d       = {CW{1'b0}};
            state_d     = IDLE;
`endif
          end else begin
            sr_d  = shift_in(sr_q, serial_in, msb_q);
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          sr_d    = {DW{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = IDLE;
          if (!frame) begin
            frame_set_s = 1'b1;
          end else if (even_parity_ok(sr_q, serial_in)) begin
            word_done_s = 1'b1;
            word_s      = sr_q;
          end else begin
            parity_set_s = 1'b1;
          end
        end
`endif
        default: begin
          sr_d    = {DW{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Holding register: a completing word is accepted only if the slot is empty or being drained.
  always_comb begin
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    overrun_set_s = 1'b0;
    if (word_done_s) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = word_s;
        dout_valid_d = 1'b1;
      end else begin
        overrun_set_s = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // Sticky status: a new event outranks a simultaneous clear.
  always_comb begin
    busy_d      = (state_d != IDLE);
    overrun_d   = overrun_set_s ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
    frame_err_d = frame_set_s   ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
`ifdef PARITY_CHECK_EN
    parity_err_d = parity_set_s ? 1'b1 : (clr_err ? 1'b0 : parity_err_q);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sr_q         <= {DW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      msb_q        <= 1'b0;
      dout_q       <= {DW{1'b0}};
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      msb_q        <= msb_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule
